// File: rtl/axi_hist_updater_if.sv
// Simplified AXI-lite register bus: AW/W/AR with valid/ready, R with rvalid only, no B channel.
interface axi_hist_updater_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output awaddr, awvalid, wdata, wvalid, araddr, arvalid,
        input  awready, wready, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, araddr, arvalid,
        output awready, wready, arready, rdata, rvalid
    );
endinterface

// File: rtl/axi_hist_updater.sv
// Histogram bin updater: read-modify-write increment of one bin count over AXI-lite,
// plus a sequential clear of all bins. One bus transaction in flight at a time.
module axi_hist_updater #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                NUM_BINS = 16,
    parameter logic [ADDR_W-1:0] BIN_BASE = 8'h00
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      bin_valid,
    input  logic [$clog2(NUM_BINS):0] bin_idx,
    output logic                      bin_ready,
    input  logic                      clr_start,
    output logic                      busy,
    output logic                      done,
    output logic                      err_range,
    output logic                      sat,
    axi_hist_updater_if.master        axi
);
    localparam int CNT_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, CLR} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [CNT_W-1:0]  clr_cnt, clr_cnt_d;
    logic              sat_pend, sat_pend_d;
    logic              done_d, err_d, sat_d;
    logic              wr_cmp, rd_take, bin_in_range, rd_max;
    logic [ADDR_W-1:0] bin_addr;

    assign bin_ready    = (state == IDLE) && !clr_start;
    assign busy         = (state != IDLE);
    assign bin_in_range = 32'(bin_idx) < 32'(NUM_BINS);
    assign bin_addr     = BIN_BASE + (ADDR_W'(bin_idx) << 2);
    assign rd_max       = (axi.rdata == '1);

    // A write channel counts as finished once its valid has dropped or it handshakes now.
    assign wr_cmp  = (!awvalid_q || axi.awready) && (!wvalid_q || axi.wready);
    assign rd_take = ((state == RD_ADDR) && axi.arready && axi.rvalid) ||
                     ((state == RD_DATA) && axi.rvalid);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d    = state;
        araddr_d   = araddr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q && !axi.awready;
        wvalid_d   = wvalid_q && !axi.wready;
        clr_cnt_d  = clr_cnt;
        sat_pend_d = sat_pend;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sat_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLR;
                    awaddr_d  = BIN_BASE;
                    wdata_d   = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    clr_cnt_d = '0;
                end else if (bin_valid) begin
                    if (bin_in_range) begin
                        state_d   = RD_ADDR;
                        araddr_d  = bin_addr;
                        arvalid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: ;
            WR: begin
                if (wr_cmp) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sat_d   = sat_pend;
                end
            end
            CLR: begin
                if (wr_cmp) begin
                    if (clr_cnt == CNT_W'(NUM_BINS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt + 1'b1;
                        awaddr_d  = awaddr_q + ADDR_W'(4);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A saturated bin is rewritten unchanged so the count never wraps to zero.
        if (rd_take) begin
            state_d    = WR;
            awaddr_d   = araddr_q;
            wdata_d    = rd_max ? axi.rdata : axi.rdata + DATA_W'(1);
            sat_pend_d = rd_max;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            clr_cnt   <= '0;
            sat_pend  <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            sat       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            clr_cnt   <= clr_cnt_d;
            sat_pend  <= sat_pend_d;
            done      <= done_d;
            err_range <= err_d;
            sat       <= sat_d;
        end
    end

    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wvalid  = wvalid_q;
endmodule

// File: tb/tb_axi_hist_updater.sv
// Directed bench for axi_hist_updater with a small AXI-lite RAM slave (configurable write stalls).
module tb_axi_hist_updater;
    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       bin_valid = 1'b0;
    logic [4:0] bin_idx = '0;
    logic       bin_ready;
    logic       clr_start = 1'b0;
    logic       busy, done, err_range, sat;

    axi_hist_updater_if #(.ADDR_W(8), .DATA_W(32)) axi ();

    axi_hist_updater #(.ADDR_W(8), .DATA_W(32), .NUM_BINS(16), .BIN_BASE(8'h00)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bin_valid (bin_valid),
        .bin_idx   (bin_idx),
        .bin_ready (bin_ready),
        .clr_start (clr_start),
        .busy      (busy),
        .done      (done),
        .err_range (err_range),
        .sat       (sat),
        .axi       (axi)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Slave model: drives ready/rvalid on the falling edge for the next rising edge.
    logic [31:0] mem [16];
    int          aw_stall = 0, w_stall = 0, aw_wait = 0, w_wait = 0;
    logic        rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [7:0]  rd_addr = '0, aw_a = '0;
    logic [31:0] w_d = '0;
    logic [7:0]  wl_addr [$];
    logic [31:0] wl_data [$];
    int          ar_cnt = 0, done_cnt = 0;

    initial begin
        axi.arready = 1'b1;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'hDEAD_BEEF;
    end

    always @(negedge aclk) begin
        if (done) done_cnt++;
        if (rd_pend) begin
            axi.rvalid = 1'b1;
            axi.rdata  = mem[rd_addr[5:2]];
            rd_pend    = 1'b0;
        end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = 32'hDEAD_BEEF;
        end
        if (axi.arvalid && axi.arready) begin
            rd_pend = 1'b1;
            rd_addr = axi.araddr;
            ar_cnt++;
        end
        if (!axi.awvalid) begin
            axi.awready = 1'b0;
            aw_wait = aw_stall;
        end else if (aw_wait > 0) begin
            axi.awready = 1'b0;
            aw_wait--;
        end else begin
            axi.awready = 1'b1;
            aw_got = 1'b1;
            aw_a = axi.awaddr;
            aw_wait = aw_stall;
        end
        if (!axi.wvalid) begin
            axi.wready = 1'b0;
            w_wait = w_stall;
        end else if (w_wait > 0) begin
            axi.wready = 1'b0;
            w_wait--;
        end else begin
            axi.wready = 1'b1;
            w_got = 1'b1;
            w_d = axi.wdata;
            w_wait = w_stall;
        end
        if (aw_got && w_got) begin
            mem[aw_a[5:2]] = w_d;
            wl_addr.push_back(aw_a);
            wl_data.push_back(w_d);
            aw_got = 1'b0;
            w_got = 1'b0;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [4:0] idx);
        bin_idx = idx;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3] = 32'd5;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        n_vec++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, busy, done, err_range, sat} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {axi.arvalid, axi.awvalid, axi.wvalid, busy, done, err_range, sat});
        end
        n_vec++;
        if ({axi.araddr, axi.awaddr, axi.wdata} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h want all 0",
                     axi.araddr, axi.awaddr, axi.wdata);
        end
        aresetn = 1'b1;
        tick();
        n_vec++;
        if (bin_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", bin_ready);
        end
    endtask

    task automatic test_single();
        issue(5'd3);
        n_vec++;
        if ({axi.arvalid, axi.araddr} !== {1'b1, 8'h0C}) begin
            n_err++;
            $display("FAIL single_ar: arvalid=%b araddr=%h want 1 0c", axi.arvalid, axi.araddr);
        end
        tick();
        n_vec++;
        if ({axi.arvalid, busy, axi.awvalid} !== 3'b010) begin
            n_err++;
            $display("FAIL single_rd: arvalid,busy,awvalid=%b want 010", {axi.arvalid, busy, axi.awvalid});
        end
        tick();
        n_vec++;
        if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata} !== {2'b11, 8'h0C, 32'h6}) begin
            n_err++;
            $display("FAIL single_wr: awv=%b wv=%b awaddr=%h wdata=%h want 1 1 0c 00000006",
                     axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata);
        end
        tick();
        n_vec++;
        if ({done, busy, bin_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL single_done: done,busy,ready=%b want 101", {done, busy, bin_ready});
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_pulse: got %b want 0", done);
        end
        n_vec++;
        if (mem[3] !== 32'd6) begin
            n_err++;
            $display("FAIL single_readback: got %h want 00000006", mem[3]);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0, dones = 0, bad_accepts = 0;
        bin_idx = 5'd7;
        bin_valid = 1'b1;
        for (int c = 0; c < 40 && dones < 3; c++) begin
            if (bin_valid && bin_ready) begin
                accepts++;
                if (busy !== 1'b0) bad_accepts++;
            end
            tick();
            if (done) begin
                dones++;
                if (dones == 3) bin_valid = 1'b0;
            end
        end
        bin_valid = 1'b0;
        n_vec++;
        if (dones !== 3) begin
            n_err++;
            $display("FAIL b2b_done: got %0d pulses want 3", dones);
        end
        n_vec++;
        if (accepts !== 3) begin
            n_err++;
            $display("FAIL b2b_accepts: got %0d want 3", accepts);
        end
        n_vec++;
        if (bad_accepts !== 0) begin
            n_err++;
            $display("FAIL b2b_accept_busy: got %0d accepts while busy want 0", bad_accepts);
        end
        n_vec++;
        if (mem[7] !== 32'd3) begin
            n_err++;
            $display("FAIL b2b_count: got %h want 00000003", mem[7]);
        end
    endtask

    task automatic test_write_stall();
        logic [2:0] exp_t [5] = '{3'b110, 3'b110, 3'b100, 3'b100, 3'b001};
        aw_stall = 3;
        w_stall = 1;
        issue(5'd3);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({axi.awvalid, axi.wvalid, done} !== exp_t[k]) begin
                n_err++;
                $display("FAIL stall_seq[%0d]: awv,wv,done=%b want %b", k,
                         {axi.awvalid, axi.wvalid, done}, exp_t[k]);
            end
            if (axi.awvalid) begin
                n_vec++;
                if ({axi.awaddr, axi.wdata} !== {8'h0C, 32'h7}) begin
                    n_err++;
                    $display("FAIL stall_stable[%0d]: awaddr=%h wdata=%h want 0c 00000007",
                             k, axi.awaddr, axi.wdata);
                end
            end
            tick();
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL stall_single_done: got %b want 0", done);
        end
        n_vec++;
        if (mem[3] !== 32'd7) begin
            n_err++;
            $display("FAIL stall_readback: got %h want 00000007", mem[3]);
        end
        aw_stall = 0;
        w_stall = 0;
    endtask

    task automatic test_sat_and_range();
        int a;
        mem[2] = 32'hFFFF_FFFF;
        issue(5'd2);
        tick();
        tick();
        n_vec++;
        if ({axi.awaddr, axi.wdata} !== {8'h08, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL sat_wr: awaddr=%h wdata=%h want 08 ffffffff", axi.awaddr, axi.wdata);
        end
        tick();
        n_vec++;
        if ({done, sat} !== 2'b11) begin
            n_err++;
            $display("FAIL sat_pulse: done,sat=%b want 11", {done, sat});
        end
        tick();
        n_vec++;
        if ({done, sat} !== 2'b00) begin
            n_err++;
            $display("FAIL sat_pulse_end: done,sat=%b want 00", {done, sat});
        end
        n_vec++;
        if (mem[2] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL sat_readback: got %h want ffffffff", mem[2]);
        end
        a = ar_cnt;
        issue(5'd16);
        n_vec++;
        if ({err_range, busy, axi.arvalid, done} !== 4'b1000) begin
            n_err++;
            $display("FAIL range_pulse: err,busy,arv,done=%b want 1000",
                     {err_range, busy, axi.arvalid, done});
        end
        tick();
        n_vec++;
        if ({err_range, axi.arvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL range_pulse_end: err,arv=%b want 00", {err_range, axi.arvalid});
        end
        n_vec++;
        if (ar_cnt !== a) begin
            n_err++;
            $display("FAIL range_no_read: got %0d reads want 0", ar_cnt - a);
        end
    endtask

    task automatic test_clear();
        int a, d0, w0, bad, nz;
        bit finished = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        a = ar_cnt;
        d0 = done_cnt;
        w0 = wl_addr.size();
        clr_start = 1'b1;
        bin_valid = 1'b1;
        bin_idx = 5'd5;
        #1;
        n_vec++;
        if (bin_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: bin_ready=%b want 0", bin_ready);
        end
        tick();
        clr_start = 1'b0;
        bin_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) begin
                finished = 1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!finished || done !== 1'b1) begin
            n_err++;
            $display("FAIL clr_done: finished=%0d done=%b want 1 1", finished, done);
        end
        repeat (3) tick();
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL clr_done_count: got %0d want 1", done_cnt - d0);
        end
        n_vec++;
        if (ar_cnt !== a) begin
            n_err++;
            $display("FAIL clr_no_read: got %0d reads want 0", ar_cnt - a);
        end
        n_vec++;
        if (wl_addr.size() - w0 !== 16) begin
            n_err++;
            $display("FAIL clr_write_count: got %0d want 16", wl_addr.size() - w0);
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (wl_addr[w0 + i] !== 8'(4 * i) || wl_data[w0 + i] !== 32'h0) bad++;
            n_vec++;
            if (bad !== 0) begin
                n_err++;
                $display("FAIL clr_order: got %0d out-of-order or nonzero writes want 0", bad);
            end
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h0) nz++;
        n_vec++;
        if (nz !== 0) begin
            n_err++;
            $display("FAIL clr_readback: got %0d nonzero bins want 0", nz);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        issue(5'd4);
        tick();
        n_vec++;
        if ({busy, axi.arvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_mid_state: busy,arv=%b want 10", {busy, axi.arvalid});
        end
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, busy, done} !== 5'b0) begin
            n_err++;
            $display("FAIL rst_mid_clear: arv,awv,wv,busy,done=%b want 00000",
                     {axi.arvalid, axi.awvalid, axi.wvalid, busy, done});
        end
        tick();
        tick();
        aresetn = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (done_cnt !== d0) begin
            n_err++;
            $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        issue(5'd4);
        repeat (3) tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_resume_done: got %b want 1", done);
        end
        n_vec++;
        if (mem[4] !== 32'd1) begin
            n_err++;
            $display("FAIL rst_mid_readback: got %h want 00000001", mem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_write_stall();
        test_sat_and_range();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
